// File: rtl/mod_pcp_pkg.sv
// Shared definitions for the PCPI modular-arithmetic coprocessor:
// instruction field helpers, operation encoding and controller states.
package mod_pcp_pkg;

    localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

    // Operation selected by func3[1:0]; func3[2] must be 0 for a claim.
    typedef enum logic [1:0] {
        MODMUL = 2'b00,
        MODADD = 2'b01,
        MODSUB = 2'b10,
        MODRED = 2'b11
    } mod_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [6:0] get_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [2:0] get_func3(input logic [31:0] insn);
        return insn[14:12];
    endfunction

    function automatic logic [6:0] get_func7(input logic [31:0] insn);
        return insn[31:25];
    endfunction

endpackage

// File: rtl/mod_iter_engine.sv
// Bit-serial modular engine: shift-and-add multiply with interleaved
// reduction (MODMUL) and restoring reduction (MODRED), one bit per cycle,
// MSB first. res is the value the accumulator takes on the current step,
// so the caller can capture the final result on the same edge as done.
module mod_iter_engine
    import mod_pcp_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter int unsigned Q    = 12289
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  mod_op_t         mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int QW = $clog2(Q);
    // Holds 2*acc + addend < 3*Q before the two conditional subtractions.
    localparam int AW = QW + 2;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [AW-1:0] QA = AW'(Q);

    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   mcand_q;
    logic [XLEN-1:0] opnd_q;
    logic [CW-1:0]   cnt_q;
    mod_op_t         mode_q;

    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   red1;
    logic [AW-1:0]   red2;

    // One iteration: double, add the current bit's contribution, then
    // subtract Q up to twice (the second is a no-op for MODRED).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        addend = '0;
        if (mode_q == MODMUL) begin
            addend = opnd_q[XLEN-1] ? mcand_q : '0;
        end else begin
            addend = AW'(opnd_q[XLEN-1]);
        end
        sum  = {acc_q[AW-2:0], 1'b0} + addend;
        red1 = (sum  >= QA) ? sum  - QA : sum;
        red2 = (red1 >= QA) ? red1 - QA : red1;
    end

    assign res  = XLEN'(red2);
    assign done = (cnt_q == CW'(1));

    // Load operands on start, then step once per cycle until the count expires.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!resetn) begin
            acc_q   <= '0;
            mcand_q <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODMUL;
        end else if (start) begin
            acc_q   <= '0;
            mode_q  <= mode;
            mcand_q <= a[AW-1:0];
            if (mode == MODMUL) begin
                // Multiplier bits QW-1..0 are moved to the MSB so both modes
                // consume opnd_q from the top.
                opnd_q <= b << (XLEN - QW);
                cnt_q  <= CW'(QW);
            end else begin
                opnd_q <= a;
                cnt_q  <= CW'(XLEN);
            end
        end else if (cnt_q != '0) begin
            acc_q  <= red2;
            opnd_q <= opnd_q << 1;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pcpi_modarith.sv
// PCPI modular-arithmetic coprocessor: decodes the custom-0 group, checks
// operand range, performs MODADD/MODSUB directly and hands MODMUL/MODRED to
// the bit-serial engine. All PCPI outputs come straight from registers.
module pcpi_modarith
    import mod_pcp_pkg::*;
#(
    parameter int          XLEN  = 32,
    parameter int unsigned Q     = 12289,
    parameter logic [6:0]  FUNC7 = 7'b0000101
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_busy,
    output logic            pcpi_ready,
    output logic            range_err
);

    localparam int QW = $clog2(Q);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] QX = XLEN'(Q);

    if (Q < 2 || longint'(Q) >= (longint'(1) << (XLEN - 2))) begin : g_q_range
        $error("pcpi_modarith: Q must satisfy 2 <= Q < 2**(XLEN-2)");
    end

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q;
    mod_op_t         op_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      f3;
    mod_op_t         op_in;
    logic            claim;
    logic            accept;
    logic            err_in;
    logic            eng_start;
    logic [CW-1:0]   n_in;
    logic            last_cyc;
    logic [XLEN-1:0] sum, add_res, sub_res, result;
    logic            eng_done;
    logic [XLEN-1:0] eng_res;

    assign f3     = get_func3(pcpi_insn);
    assign op_in  = mod_op_t'(f3[1:0]);
    assign claim  = pcpi_valid && (get_opcode(pcpi_insn) == CUSTOM0_OPCODE) &&
                    (get_func7(pcpi_insn) == FUNC7) && !f3[2];
    assign accept = (state_q == ST_IDLE) && claim;

    assign err_in    = (op_in != MODRED) && ((pcpi_rs1 >= QX) || (pcpi_rs2 >= QX));
    assign eng_start = accept && !err_in && ((op_in == MODMUL) || (op_in == MODRED));
    assign last_cyc  = (state_q == ST_EXEC) && (cnt_q == CW'(1));

    // Cycle count for the accepted instruction.
    always_comb begin
        n_in = CW'(1);
        if (!err_in) begin
            case (op_in)
                MODMUL:  n_in = CW'(QW);
                MODRED:  n_in = CW'(XLEN);
                default: n_in = CW'(1);
            endcase
        end
    end

    // Single-cycle add/sub on the latched operands and final result select.
    always_comb begin
        sum     = a_q + b_q;
        add_res = (sum >= QX) ? sum - QX : sum;
        sub_res = (a_q >= b_q) ? a_q - b_q : a_q - b_q + QX;
        result  = eng_res;
        if (err_q) begin
            result = '1;
        end else begin
            case (op_q)
                MODADD:  result = add_res;
                MODSUB:  result = sub_res;
                default: result = eng_res;
            endcase
        end
    end

    mod_iter_engine #(
        .XLEN (XLEN),
        .Q    (Q)
    ) u_engine (
        .clk    (clk),
        .resetn (resetn),
        .start  (eng_start),
        .mode   (op_in),
        .a      (pcpi_rs1),
        .b      (pcpi_rs2),
        .done   (eng_done),
        .res    (eng_res)
    );

    // Controller next-state: DONE waits for pcpi_valid low to avoid re-execution.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (claim)      state_d = ST_EXEC;
            ST_EXEC: if (last_cyc)   state_d = ST_DONE;
            ST_DONE: if (!pcpi_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches, cycle counter and registered PCPI outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= MODMUL;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_busy  <= 1'b0;
            pcpi_ready <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            pcpi_wr    <= 1'b0;
            pcpi_ready <= 1'b0;
            range_err  <= 1'b0;
            if (accept) begin
                a_q       <= pcpi_rs1;
                b_q       <= pcpi_rs2;
                op_q      <= op_in;
                err_q     <= err_in;
                cnt_q     <= n_in;
                pcpi_busy <= 1'b1;
            end
            if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (last_cyc) begin
                pcpi_rd    <= result;
                pcpi_wr    <= 1'b1;
                pcpi_ready <= 1'b1;
                range_err  <= err_q;
                pcpi_busy  <= 1'b0;
            end
        end
    end

    // The engine's own bit counter must expire on the controller's last cycle.
    always_ff @(posedge clk) begin
        if (resetn && (state_q == ST_EXEC) && !err_q &&
            ((op_q == MODMUL) || (op_q == MODRED))) begin
            assert (eng_done == (cnt_q == CW'(1)));
        end
    end

endmodule
